// File: rtl/dpwm_comparador.sv
// Digital PWM comparator: stepped duty request (sube/baja), period-aligned duty load, registered pwm.
// Optional complementary output enabled by `define PWM_COMPLEMENTARIO_EN (otherwise pwm_n is tied 0).
module dpwm_comparador (
  input  logic       CLK,
  input  logic       reset,
  input  logic [9:0] cuenta,
  input  logic       sube,
  input  logic       baja,
  output logic [9:0] duty,
  output logic       pwm,
  output logic       pwm_n
);

  localparam logic [9:0] DUTY_RST = 10'd500;
  localparam logic [9:0] DUTY_MAX = 10'd1000;
  localparam logic [9:0] STEP     = 10'd50;

  logic       sube_q, baja_q;
  logic [9:0] duty_sig_q, duty_sig_d;
  logic [9:0] duty_q, duty_d;
  logic       pwm_q, pwm_d;
  logic       sube_edge, baja_edge, boundary;
  logic [9:0] thr;

  assign sube_edge = sube & ~sube_q;
  assign baja_edge = baja & ~baja_q;
  assign boundary  = (cuenta == 10'd0);

  // Saturation tests happen before the add/subtract, so no wrap is possible.
  always_comb begin
    duty_sig_d = duty_sig_q;
    if (sube_edge && !baja_edge)
      duty_sig_d = (duty_sig_q >= DUTY_MAX - STEP) ? DUTY_MAX : duty_sig_q + STEP;
    else if (baja_edge && !sube_edge)
      duty_sig_d = (duty_sig_q <= STEP) ? 10'd0 : duty_sig_q - STEP;
  end

  // At the boundary the period starts on the pending value already latched
  // (an edge in this same cycle only lands one period later).
  always_comb begin
    duty_d = boundary ? duty_sig_q : duty_q;
    thr    = boundary ? duty_sig_q : duty_q;
    pwm_d  = (thr >= DUTY_MAX) || (cuenta < thr);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sube_q     <= 1'b0;
      baja_q     <= 1'b0;
      duty_sig_q <= DUTY_RST;
      duty_q     <= DUTY_RST;
      pwm_q      <= 1'b0;
    end else begin
      sube_q     <= sube;
      baja_q     <= baja;
      duty_sig_q <= duty_sig_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
    end
  end

`ifdef PWM_COMPLEMENTARIO_EN
  logic pwm_n_q;
  always_ff @(posedge CLK) begin
    if (reset) pwm_n_q <= 1'b0;
    else       pwm_n_q <= ~pwm_d;
  end
  assign pwm_n = pwm_n_q;
`else
  assign pwm_n = 1'b0;
`endif

  assign duty = duty_q;
  assign pwm  = pwm_q;

endmodule

// File: tb/tb_dpwm_comparador.sv
// Bench for dpwm_comparador: per-cycle reference model plus directed literal checks.
module tb_dpwm_comparador;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] cuenta = 10'd0;
  logic       sube = 1'b0, baja = 1'b0;
  logic [9:0] duty;
  logic       pwm, pwm_n;

  int vectors = 0, miscompares = 0;
  int cnt_idx = 0;

  dpwm_comparador dut (
    .CLK(CLK), .reset(reset), .cuenta(cuenta), .sube(sube), .baja(baja),
    .duty(duty), .pwm(pwm), .pwm_n(pwm_n)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending request steps by 50 within [0,1000] on fresh
  // presses, the active duty is taken from the request at each period start,
  // and pwm is high while the count sits below the period's threshold.
  int  m_req = 500, m_act = 500;
  bit  m_pwm = 0, m_prev_s = 0, m_prev_b = 0, m_valid = 0;

  always @(posedge CLK) begin
    int  req, act, thr;
    bit  ps, pb;
    if (reset) begin
      m_req <= 500; m_act <= 500; m_pwm <= 0;
      m_prev_s <= 0; m_prev_b <= 0; m_valid <= 1;
    end else begin
      ps  = sube && !m_prev_s;
      pb  = baja && !m_prev_b;
      req = m_req;
      if (ps && !pb) req = (m_req + 50 > 1000) ? 1000 : m_req + 50;
      if (pb && !ps) req = (m_req - 50 < 0) ? 0 : m_req - 50;
      act = (cuenta == 0) ? m_req : m_act;
      thr = act;
      m_pwm    <= (thr == 1000) || (int'(cuenta) < thr);
      m_act    <= act;
      m_req    <= req;
      m_prev_s <= sube;
      m_prev_b <= baja;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      bit exp_n;
`ifdef PWM_COMPLEMENTARIO_EN
      exp_n = reset ? 1'b0 : ~m_pwm;
      if (reset) exp_n = 1'b0;
`else
      exp_n = 1'b0;
`endif
      vectors++;
      if (duty !== 10'(m_act) || pwm !== m_pwm || pwm_n !== exp_n) begin
        miscompares++;
        $display("FAIL model t=%0t duty=%0d/%0d pwm=%b/%b pwm_n=%b/%b (got/exp)",
                 $time, duty, m_act, pwm, m_pwm, pwm_n, exp_n);
      end
    end
  end

  task automatic raw_tick();
    @(posedge CLK); #1;
  endtask

  task automatic tick();
    raw_tick();
    cnt_idx = (cnt_idx + 1) % 21;
    cuenta  = 10'(cnt_idx * 50);
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Tick until the DUT has just taken the period-boundary edge.
  task automatic wait_boundary();
    int n = 0;
    while (cuenta != 0 && n < 50) begin tick(); n++; end
    if (n >= 50) check("boundary_timeout", n, 0);
    tick();
  endtask

  // Count pwm highs across one full period, starting right after the boundary edge.
  task automatic count_period(input string name, input int exp);
    int hi = 0;
    for (int i = 0; i < 21; i++) begin hi += int'(pwm); tick(); end
    check(name, hi, exp);
  endtask

  task automatic pulse(input bit up);
    if (up) sube = 1; else baja = 1;
    tick();
    sube = 0; baja = 0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1; cnt_idx = 0; cuenta = 0;
    raw_tick(); raw_tick();
    reset = 0;
  endtask

  initial begin
    do_reset();
    check("rst_duty", duty, 500);
    check("rst_pwm", pwm, 0);
    check("rst_pwm_n", pwm_n, 0);

    // Free-running counter at 500: 10 high, 11 low.
    tick(); tick();
    wait_boundary();
    count_period("period_500", 10);

    // Held sube mid-period: one step only, active from next period.
    while (cuenta != 200) tick();
    sube = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cuenta == 0) check("hold_before_bnd", duty, 500);
    end
    sube = 0;
    wait_boundary();
    check("hold_after_bnd", duty, 550);
    count_period("period_550", 11);

    // Saturate high.
    do_reset();
    for (int i = 0; i < 11; i++) pulse(1);
    wait_boundary();
    check("sat_hi_duty", duty, 1000);
    count_period("period_1000", 21);

    // Saturate low.
    do_reset();
    for (int i = 0; i < 11; i++) pulse(0);
    wait_boundary();
    check("sat_lo_duty", duty, 0);
    count_period("period_0", 0);

    // Simultaneous edges cancel.
    do_reset();
    sube = 1; baja = 1; tick(); sube = 0; baja = 0; tick();
    wait_boundary();
    check("both_edges", duty, 500);

    // Edge on the boundary cycle: duty moves one period late.
    while (cuenta != 0) tick();
    sube = 1; tick(); sube = 0;
    check("edge_at_bnd_now", duty, 500);
    wait_boundary();
    check("edge_at_bnd_next", duty, 550);

    // Off-grid and out-of-range counts: plain compare, no load.
    pulse(1);                      // request 600, active still 550
    cuenta = 10'd525; raw_tick();
    check("odd_525_pwm", pwm, 1);
    cuenta = 10'd575; raw_tick();
    check("odd_575_pwm", pwm, 0);
    cuenta = 10'd1023; raw_tick();
    check("over_1023_pwm", pwm, 0);
    check("over_no_load", duty, 550);
    cnt_idx = 0; cuenta = 0; raw_tick();
    check("load_600", duty, 600);
    cnt_idx = 1; cuenta = 10'd50;

    // Reset mid-period with duty 700.
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1);
    wait_boundary();
    check("duty_700", duty, 700);
    while (cuenta != 300) tick();
    reset = 1; raw_tick();
    check("midrst_duty", duty, 500);
    check("midrst_pwm", pwm, 0);
    check("midrst_pwm_n", pwm_n, 0);
    reset = 0; cnt_idx = 0; cuenta = 0;
    for (int i = 0; i < 25; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
